// File: rtl/updown_mod_counter.sv
// Up/down modulo counter with wrap or saturate at 0/MOD_MAX, sync clear and clamped load.
// Latency: 1 cycle to count/wrap/limit; no backpressure, one step per enabled cycle.
module updown_mod_counter #(
  parameter int unsigned          WIDTH    = 4,
  parameter logic [WIDTH-1:0]     MOD_MAX  = {WIDTH{1'b1}},
  parameter bit                   SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             en,
  input  logic             up,
  output logic [WIDTH-1:0] count,
  output logic             at_zero,
  output logic             at_max,
  output logic             wrap,
  output logic             limit
);

  localparam logic [WIDTH-1:0] ZERO = '0;
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  logic [WIDTH-1:0] count_nxt;
  logic             wrap_nxt;
  logic             limit_nxt;
  logic             hit_max;
  logic             hit_zero;

  // >= guards against stepping past MOD_MAX without relying on WIDTH-bit overflow
  assign hit_max  = (count >= MOD_MAX);
  assign hit_zero = (count == ZERO);

  always_comb begin
    count_nxt = count;
    wrap_nxt  = 1'b0;
    limit_nxt = 1'b0;
    if (clear) begin
      count_nxt = ZERO;
    end else if (load) begin
      count_nxt = (load_data > MOD_MAX) ? MOD_MAX : load_data;
    end else if (en) begin
      if (up) begin
        if (!hit_max) begin
          count_nxt = count + ONE;
        end else if (SATURATE) begin
          limit_nxt = 1'b1;
        end else begin
          count_nxt = ZERO;
          wrap_nxt  = 1'b1;
        end
      end else begin
        if (!hit_zero) begin
          count_nxt = count - ONE;
        end else if (SATURATE) begin
          limit_nxt = 1'b1;
        end else begin
          count_nxt = MOD_MAX;
          wrap_nxt  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= ZERO;
      wrap  <= 1'b0;
      limit <= 1'b0;
    end else begin
      count <= count_nxt;
      wrap  <= wrap_nxt;
      limit <= limit_nxt;
    end
  end

  assign at_zero = (count == ZERO);
  assign at_max  = (count == MOD_MAX);

endmodule

// File: tb/tb_updown_mod_counter.sv
// Directed bench: default (mod 16 wrap), mod 10 wrap and mod 10 saturate instances.
module tb_updown_mod_counter;

  logic clk;
  logic reset;

  logic       a_clear, a_load, a_en, a_up;
  logic [3:0] a_ld, a_count;
  logic       a_z, a_m, a_w, a_l;

  logic       w_clear, w_load, w_en, w_up;
  logic [3:0] w_ld, w_count;
  logic       w_z, w_m, w_w, w_l;

  logic       s_clear, s_load, s_en, s_up;
  logic [3:0] s_ld, s_count;
  logic       s_z, s_m, s_w, s_l;

  int tests;
  int fails;

  updown_mod_counter #(.WIDTH(4)) dut_a (
    .clk(clk), .reset(reset), .clear(a_clear), .load(a_load), .load_data(a_ld),
    .en(a_en), .up(a_up), .count(a_count), .at_zero(a_z), .at_max(a_m),
    .wrap(a_w), .limit(a_l)
  );

  updown_mod_counter #(.WIDTH(4), .MOD_MAX(4'd9), .SATURATE(1'b0)) dut_w (
    .clk(clk), .reset(reset), .clear(w_clear), .load(w_load), .load_data(w_ld),
    .en(w_en), .up(w_up), .count(w_count), .at_zero(w_z), .at_max(w_m),
    .wrap(w_w), .limit(w_l)
  );

  updown_mod_counter #(.WIDTH(4), .MOD_MAX(4'd9), .SATURATE(1'b1)) dut_s (
    .clk(clk), .reset(reset), .clear(s_clear), .load(s_load), .load_data(s_ld),
    .en(s_en), .up(s_up), .count(s_count), .at_zero(s_z), .at_max(s_m),
    .wrap(s_w), .limit(s_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    reset = 1'b1;
    {a_clear, a_load, a_en, a_up, a_ld} = '0;
    {w_clear, w_load, w_en, w_up, w_ld} = '0;
    {s_clear, s_load, s_en, s_up, s_ld} = '0;

    #1;
    chk("rst_a_count", a_count, 0);
    chk("rst_a_zero", a_z, 1);
    chk("rst_a_max", a_m, 0);
    chk("rst_a_wrap", a_w, 0);
    chk("rst_a_limit", a_l, 0);
    chk("rst_w_count", w_count, 0);
    chk("rst_s_count", s_count, 0);

    step();
    reset = 1'b0;

    // Count to 5, then async reset between edges
    a_en = 1'b1;
    a_up = 1'b1;
    repeat (5) step();
    chk("a_up5", a_count, 5);
    #2 reset = 1'b1;
    #1;
    chk("a_async_rst_count", a_count, 0);
    chk("a_async_rst_zero", a_z, 1);
    chk("a_async_rst_wrap", a_w, 0);
    chk("a_async_rst_limit", a_l, 0);
    #1 reset = 1'b0;
    step();
    chk("a_after_rst_1", a_count, 1);
    step();
    chk("a_after_rst_2", a_count, 2);

    // Load beats enable in the same cycle
    a_load = 1'b1;
    a_ld   = 4'b0111;
    step();
    chk("a_load_no_inc", a_count, 7);
    a_load = 1'b0;
    step();
    chk("a_inc_after_load", a_count, 8);

    // Hold with en=0, direction toggling is ignored
    a_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      a_up = ~a_up;
      step();
      chk("a_hold_count", a_count, 8);
      chk("a_hold_wrap", a_w, 0);
    end

    // Full range from 0 and natural-width wrap
    a_clear = 1'b1;
    step();
    chk("a_clear", a_count, 0);
    a_clear = 1'b0;
    a_en    = 1'b1;
    a_up    = 1'b1;
    repeat (15) step();
    chk("a_full_15", a_count, 15);
    chk("a_full_max", a_m, 1);
    chk("a_full_nowrap", a_w, 0);
    step();
    chk("a_wrap16_count", a_count, 0);
    chk("a_wrap16_wrap", a_w, 1);
    chk("a_wrap16_zero", a_z, 1);
    step();
    chk("a_post_wrap_count", a_count, 1);
    chk("a_post_wrap_wrap", a_w, 0);
    a_en = 1'b0;

    // MOD_MAX=9 wrap up and down
    w_load = 1'b1;
    w_ld   = 4'd9;
    step();
    chk("w_load9", w_count, 9);
    chk("w_load9_max", w_m, 1);
    w_load = 1'b0;
    w_en   = 1'b1;
    w_up   = 1'b1;
    step();
    chk("w_upwrap_count", w_count, 0);
    chk("w_upwrap_wrap", w_w, 1);
    chk("w_upwrap_zero", w_z, 1);
    w_en = 1'b0;
    step();
    chk("w_wrap_pulse_end", w_w, 0);
    chk("w_hold0", w_count, 0);
    w_en = 1'b1;
    w_up = 1'b0;
    step();
    chk("w_dnwrap_count", w_count, 9);
    chk("w_dnwrap_wrap", w_w, 1);
    chk("w_dnwrap_max", w_m, 1);
    chk("w_dnwrap_limit", w_l, 0);
    step();
    chk("w_dec8", w_count, 8);
    chk("w_dec8_wrap", w_w, 0);

    // Reset cancels an in-flight wrap pulse
    w_en    = 1'b0;
    w_clear = 1'b1;
    step();
    w_clear = 1'b0;
    w_en    = 1'b1;
    step();
    chk("w_pre_rst_wrap", w_w, 1);
    #2 reset = 1'b1;
    #1;
    chk("w_rst_cancel_wrap", w_w, 0);
    chk("w_rst_cancel_count", w_count, 0);
    #1 reset = 1'b0;
    w_en = 1'b0;

    // Load clamp and clear-over-load priority
    w_load = 1'b1;
    w_ld   = 4'd12;
    step();
    chk("w_clamp", w_count, 9);
    w_clear = 1'b1;
    w_ld    = 4'd5;
    step();
    chk("w_clear_beats_load", w_count, 0);
    w_clear = 1'b0;
    w_load  = 1'b0;

    // MOD_MAX=9 saturate
    s_load = 1'b1;
    s_ld   = 4'd9;
    step();
    chk("s_load9", s_count, 9);
    s_load = 1'b0;
    s_en   = 1'b1;
    s_up   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("s_sat_count", s_count, 9);
      chk("s_sat_limit", s_l, 1);
      chk("s_sat_wrap", s_w, 0);
    end
    s_up = 1'b0;
    step();
    chk("s_down8", s_count, 8);
    chk("s_down8_limit", s_l, 0);
    s_en    = 1'b0;
    s_clear = 1'b1;
    step();
    s_clear = 1'b0;
    s_en    = 1'b1;
    step();
    chk("s_low_sat_count", s_count, 0);
    chk("s_low_sat_limit", s_l, 1);
    chk("s_low_sat_wrap", s_w, 0);
    s_en = 1'b0;
    step();
    chk("s_limit_end", s_l, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
